// File: rtl/cohort_fifo_ptr_ctrl_if.sv
// Handshake and mirror bundle between the cohort pointer engine and its neighbours.
// The slave side is the pointer engine; the master side drives mirrors and handshakes.
interface cohort_fifo_ptr_ctrl_if #(
    parameter int reg_width = 128,
    parameter int PtrWidth  = 64,
    parameter int CntWidth  = 32
);
    logic                 element_fetched_i;
    logic [reg_width-1:0] p_fifo_info_i;
    logic [reg_width-1:0] p_head_ptr_i;
    logic [reg_width-1:0] c_fifo_info_i;
    logic [reg_width-1:0] c_tail_ptr_i;
    logic                 push_valid_i;
    logic                 push_ready_o;
    logic                 pop_valid_o;
    logic                 pop_ready_i;
    logic [PtrWidth-1:0]  producer_tail_ptr_o;
    logic [PtrWidth-1:0]  consumer_head_ptr_o;
    logic [CntWidth-1:0]  p_count_o;
    logic [CntWidth-1:0]  c_count_o;
    logic                 cfg_err_o;

    modport slave (
        input  element_fetched_i, p_fifo_info_i, p_head_ptr_i, c_fifo_info_i, c_tail_ptr_i,
        input  push_valid_i, pop_ready_i,
        output push_ready_o, pop_valid_o, producer_tail_ptr_o, consumer_head_ptr_o,
        output p_count_o, c_count_o, cfg_err_o
    );

    modport master (
        output element_fetched_i, p_fifo_info_i, p_head_ptr_i, c_fifo_info_i, c_tail_ptr_i,
        output push_valid_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, producer_tail_ptr_o, consumer_head_ptr_o,
        input  p_count_o, c_count_o, cfg_err_o
    );
endinterface

// File: rtl/cohort_fifo_ptr_ctrl.sv
// Local tail/head pointer engine for a cohort tile's producer and consumer FIFOs.
// Remote ends are seen through coherent mirrors; depths are latched when the tile starts running.
module cohort_fifo_ptr_ctrl #(
    parameter int reg_width = 128,
    parameter int PtrWidth  = 64,
    parameter int CntWidth  = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    cohort_fifo_ptr_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERR} state_t;

    localparam logic [PtrWidth-1:0] PTR_ONE   = PtrWidth'(1);
    localparam logic [CntWidth-1:0] MIN_DEPTH = CntWidth'(2);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CntWidth-1:0] r_p_depth;
    logic [CntWidth-1:0] r_c_depth;
    logic [PtrWidth-1:0] r_tail;
    logic [PtrWidth-1:0] r_head;
    logic [CntWidth-1:0] r_p_cnt;
    logic [CntWidth-1:0] r_c_cnt;

    logic [PtrWidth-1:0] w_p_head;
    logic [PtrWidth-1:0] w_c_tail;
    logic [CntWidth-1:0] w_p_depth_in;
    logic [CntWidth-1:0] w_c_depth_in;
    logic [PtrWidth-1:0] w_p_depth;
    logic [PtrWidth-1:0] w_c_depth;
    logic [PtrWidth-1:0] w_tail_nxt;
    logic [PtrWidth-1:0] w_head_nxt;
    logic [PtrWidth-1:0] w_p_cnt;
    logic [PtrWidth-1:0] w_c_cnt;
    logic                w_run;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_cfg_ok;
    logic                w_ptr_oob;
    logic                w_unused;

    // Only the low fields of the mirrored words carry meaning.
    assign w_p_head     = bus.p_head_ptr_i[PtrWidth-1:0];
    assign w_c_tail     = bus.c_tail_ptr_i[PtrWidth-1:0];
    assign w_p_depth_in = bus.p_fifo_info_i[CntWidth-1:0];
    assign w_c_depth_in = bus.c_fifo_info_i[CntWidth-1:0];
    assign w_unused     = ^{bus.p_head_ptr_i[reg_width-1:PtrWidth], bus.c_tail_ptr_i[reg_width-1:PtrWidth],
                            bus.p_fifo_info_i[reg_width-1:CntWidth], bus.c_fifo_info_i[reg_width-1:CntWidth]};

    assign w_p_depth = {{(PtrWidth-CntWidth){1'b0}}, r_p_depth};
    assign w_c_depth = {{(PtrWidth-CntWidth){1'b0}}, r_c_depth};

    // Modulo-depth increment; depths need not be powers of two.
    assign w_tail_nxt = (r_tail == w_p_depth - PTR_ONE) ? '0 : r_tail + PTR_ONE;
    assign w_head_nxt = (r_head == w_c_depth - PTR_ONE) ? '0 : r_head + PTR_ONE;

    assign w_run     = (r_state == ST_RUN);
    assign w_full    = (w_tail_nxt == w_p_head);
    assign w_empty   = (r_head == w_c_tail);
    assign w_push    = w_run & ~w_full & bus.push_valid_i;
    assign w_pop     = w_run & ~w_empty & bus.pop_ready_i;
    assign w_cfg_ok  = (w_p_depth_in >= MIN_DEPTH) && (w_c_depth_in >= MIN_DEPTH);
    assign w_ptr_oob = (w_p_head >= w_p_depth) || (w_c_tail >= w_c_depth);

    assign w_p_cnt = (r_tail >= w_p_head) ? r_tail - w_p_head : r_tail + w_p_depth - w_p_head;
    assign w_c_cnt = (w_c_tail >= r_head) ? w_c_tail - r_head : w_c_tail + w_c_depth - r_head;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.element_fetched_i) w_state_nxt = w_cfg_ok ? ST_RUN : ST_ERR;
            ST_RUN: begin
                if (!bus.element_fetched_i) w_state_nxt = ST_IDLE;
                else if (w_ptr_oob)         w_state_nxt = ST_ERR;
            end
            ST_ERR:  if (!bus.element_fetched_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_p_depth <= '0;
            r_c_depth <= '0;
            r_tail    <= '0;
            r_head    <= '0;
            r_p_cnt   <= '0;
            r_c_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_RUN) begin
                r_p_depth <= w_p_depth_in;
                r_c_depth <= w_c_depth_in;
            end
            if (w_state_nxt == ST_IDLE) begin
                r_tail <= '0;
                r_head <= '0;
            end else begin
                if (w_push) r_tail <= w_tail_nxt;
                if (w_pop)  r_head <= w_head_nxt;
            end
            r_p_cnt <= w_run ? w_p_cnt[CntWidth-1:0] : '0;
            r_c_cnt <= w_run ? w_c_cnt[CntWidth-1:0] : '0;
        end
    end

    assign bus.push_ready_o        = w_run & ~w_full;
    assign bus.pop_valid_o         = w_run & ~w_empty;
    assign bus.producer_tail_ptr_o = r_tail;
    assign bus.consumer_head_ptr_o = r_head;
    assign bus.p_count_o           = r_p_cnt;
    assign bus.c_count_o           = r_c_cnt;
    assign bus.cfg_err_o           = (r_state == ST_ERR);
endmodule
